caretaker_driver: RTL and testbench
===================================

Name: caretaker_driver

Overview:
Closed-loop stimulus initiator for the mimosa pet core; it drives the pet's tick clock and 7-bit stimulus bus from the opposite side of that interface. It samples the pet's energy, stress and pleasure indicators plus the asleep flag once per tick period. It selects one care action by fixed priority, then issues it as a stimulus word framed around a single-cycle tick pulse. It is used for self-play demos and for bench-driving the pet core.

Parameters:
TICK_DIV, 16, system-clock cycles per pet tick; legal range 4..255
REPEAT_MAX, 3, max consecutive identical non-empty actions before one forced empty tick; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
enable  input  1  run request; sampled every cycle
energy_indicator  input  2  pet energy class: 00 low, 01 mid-low, 10 mid-high, 11 high
stress_indicator  input  2  pet stress class, same encoding
pleasure_indicator  input  2  pet pleasure class, same encoding
asleep  input  1  pet sleep flag
tick  output  1  pet clock pulse; connects to the pet's stimulus-bus bit 0
stimuli  output  7  one-hot action or all-zero; connects to the pet's stimulus-bus bits 7:1
action_count  output  8  count of non-empty actions issued; saturates at 255

Behaviour:
- All outputs are registered. Reset drives tick=0, stimuli=0, action_count=0, div=0, state IDLE, last_action=0 and repeat_cnt=0, asynchronously and at any point mid-sequence.
- Stimulus bit map: [0] feed, [1] pet, [2] play, [3] soothe, [4] noise, [5] poke, [6] light. This block issues only feed, pet, play and soothe.
- Divider div counts 0..TICK_DIV-1 and wraps while enable=1 or while the FSM is not IDLE. When enable=0 and the FSM is IDLE, div is held at 0.
- FSM states: IDLE, SETUP, TICK, HOLD.
  - Edge where state=IDLE, enable=1 and div==TICK_DIV-1: sample inputs, compute the action, go to SETUP, load stimuli<=action.
  - SETUP -> TICK: tick<=1.
  - TICK -> HOLD: tick<=0.
  - HOLD -> IDLE: stimuli<=0.
- Resulting frame: stimuli is stable for 3 cycles, tick is high for exactly the middle cycle, and the tick period is TICK_DIV cycles.
- Frame completion: once SETUP is entered, the frame always completes, even if enable drops. No new frame starts while enable=0.
- Action priority, first match wins:
  1. asleep=1 -> empty (0).
  2. stress=11 -> soothe.
  3. energy=00 -> feed.
  4. pleasure<=01 -> play if energy>=10, else pet.
  5. pleasure=10 -> pet.
  6. Otherwise -> empty.
- Repeat limiter, applied after priority selection:
  - Empty choice: last_action=0, repeat_cnt=0.
  - Choice equals last_action and repeat_cnt==REPEAT_MAX: issue empty, set last_action=0, repeat_cnt=0.
  - Choice equals last_action, limit not reached: repeat_cnt+1.
  - Choice differs from last_action: last_action=choice, repeat_cnt=1.
- An empty frame still produces the tick pulse, so pet time always advances while enabled.
- action_count increments on the SETUP entry edge when the issued action is non-empty. It holds at 255.
- Indicator inputs are sampled only on the frame-start edge; changes at any other time are ignored.

Optional Feature:
MIMOSA_MANUAL_OVERRIDE_EN
- Defined: extra ports manual_valid (input 1), manual_stim (input 7) and manual_ack (output 1, reset 0).
  - One-entry buffer captures manual_stim when manual_valid=1 and the buffer is empty. A request arriving while the buffer is full is dropped.
  - At the next frame start, a full buffer overrides the priority logic and the repeat limiter; any bit pattern is passed, including multi-bit patterns. The limiter registers are untouched.
  - The buffer empties on that edge, manual_ack pulses for 1 cycle on that edge, and action_count increments if the pattern is non-zero.
  - Reset clears the buffer.
- Undefined: ports absent; behaviour is exactly as above.

Test Plan:
- TICK_DIV=8, enable=1 from reset release, stress=11, other indicators 10, asleep=0 -> frame starts when div reaches 7; stimuli=0001000 for 3 cycles; tick high in the middle cycle; next tick 8 cycles later; action_count=1 after the first frame.
- asleep=1, stress=11 -> tick keeps pulsing every TICK_DIV cycles; stimuli stays 0; action_count unchanged.
- REPEAT_MAX=3, energy=00 held -> action sequence feed,feed,feed,empty,feed,feed,feed,empty; action_count=6 after 8 frames.
- enable dropped on the TICK cycle -> frame completes (HOLD, then IDLE with stimuli=0); no further tick; div stays 0; re-enable -> first tick occurs TICK_DIV-1+2 cycles later.
- rst pulsed during HOLD with stimuli=0000100 -> tick, stimuli and action_count immediately 0; limiter cleared, so after release the same play choice counts as repeat 1.
- With MIMOSA_MANUAL_OVERRIDE_EN, manual_stim=1000000 pulsed while stress=11 -> next frame stimuli=1000000; manual_ack pulses once; the frame after that issues soothe.

Source files
------------

// File: rtl/caretaker_driver.sv
// caretaker_driver: closed-loop care-action initiator that clocks and stimulates the mimosa pet core.
// Define MIMOSA_MANUAL_OVERRIDE_EN to add the one-entry manual stimulus injection port.
module caretaker_driver #(
  parameter int TICK_DIV   = 16,
  parameter int REPEAT_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] energy_indicator,
  input  logic [1:0] stress_indicator,
  input  logic [1:0] pleasure_indicator,
  input  logic       asleep,
`ifdef MIMOSA_MANUAL_OVERRIDE_EN
  input  logic       manual_valid,
  input  logic [6:0] manual_stim,
  output logic       manual_ack,
`endif
  output logic       tick,
  output logic [6:0] stimuli,
  output logic [7:0] action_count
);

  localparam logic [6:0] FEED      = 7'b0000001;
  localparam logic [6:0] PET       = 7'b0000010;
  localparam logic [6:0] PLAY      = 7'b0000100;
  localparam logic [6:0] SOOTHE    = 7'b0001000;
  localparam logic [7:0] DIV_LAST  = 8'(TICK_DIV - 1);
  localparam logic [3:0] REP_LIMIT = 4'(REPEAT_MAX);

  typedef enum logic [1:0] {IDLE, SETUP, TICK, HOLD} state_t;

  state_t     state_reg, state_next;
  logic [7:0] div_reg;
  logic [6:0] last_action_reg, last_action_next;
  logic [3:0] repeat_cnt_reg, repeat_cnt_next;
  logic       tick_next;
  logic [6:0] stimuli_next;
  logic [7:0] action_count_next;
  logic [6:0] choice, limited, issued, lim_last;
  logic [3:0] lim_cnt;
  logic       frame_start;
  logic       override;

  assign frame_start = (state_reg == IDLE) && enable && (div_reg == DIV_LAST);

  // Divider free-runs while enabled or mid-frame, and parks at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_reg <= '0;
    else if (enable || state_reg != IDLE)
      div_reg <= (div_reg == DIV_LAST) ? 8'd0 : div_reg + 8'd1;
    else
      div_reg <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start) state_next = SETUP;
      SETUP:   state_next = TICK;
      TICK:    state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    choice = '0;
    if (asleep)                            choice = '0;
    else if (stress_indicator == 2'b11)    choice = SOOTHE;
    else if (energy_indicator == 2'b00)    choice = FEED;
    else if (pleasure_indicator <= 2'b01)  choice = (energy_indicator >= 2'b10) ? PLAY : PET;
    else if (pleasure_indicator == 2'b10)  choice = PET;
  end

  always_comb begin
    limited  = choice;
    lim_last = last_action_reg;
    lim_cnt  = repeat_cnt_reg;
    if (choice == '0) begin
      lim_last = '0;
      lim_cnt  = '0;
    end else if (choice == last_action_reg) begin
      if (repeat_cnt_reg == REP_LIMIT) begin
        limited  = '0;
        lim_last = '0;
        lim_cnt  = '0;
      end else begin
        lim_cnt = repeat_cnt_reg + 4'd1;
      end
    end else begin
      lim_last = choice;
      lim_cnt  = 4'd1;
    end
  end

`ifdef MIMOSA_MANUAL_OVERRIDE_EN
  logic       buf_full_reg;
  logic [6:0] buf_reg;

  assign override = buf_full_reg;
  assign issued   = buf_full_reg ? buf_reg : limited;

  // A full buffer is consumed at frame start; requests arriving while full are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full_reg <= 1'b0;
      buf_reg      <= '0;
      manual_ack   <= 1'b0;
    end else begin
      manual_ack <= frame_start && buf_full_reg;
      if (frame_start && buf_full_reg) begin
        buf_full_reg <= 1'b0;
      end else if (manual_valid && !buf_full_reg) begin
        buf_full_reg <= 1'b1;
        buf_reg      <= manual_stim;
      end
    end
  end
`else
  assign override = 1'b0;
  assign issued   = limited;
`endif

  always_comb begin
    tick_next         = tick;
    stimuli_next      = stimuli;
    action_count_next = action_count;
    last_action_next  = last_action_reg;
    repeat_cnt_next   = repeat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          stimuli_next = issued;
          if (issued != '0 && action_count != 8'hFF)
            action_count_next = action_count + 8'd1;
          if (!override) begin
            last_action_next = lim_last;
            repeat_cnt_next  = lim_cnt;
          end
        end
      end
      SETUP:   tick_next    = 1'b1;
      TICK:    tick_next    = 1'b0;
      HOLD:    stimuli_next = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick            <= 1'b0;
      stimuli         <= '0;
      action_count    <= '0;
      last_action_reg <= '0;
      repeat_cnt_reg  <= '0;
    end else begin
      tick            <= tick_next;
      stimuli         <= stimuli_next;
      action_count    <= action_count_next;
      last_action_reg <= last_action_next;
      repeat_cnt_reg  <= repeat_cnt_next;
    end
  end

endmodule

// File: tb/tb_caretaker_driver.sv
// tb_caretaker_driver: randomized frame-level check of caretaker_driver against a rule-based care model.
// Exercises the manual override path as well when MIMOSA_MANUAL_OVERRIDE_EN is defined.
module tb_caretaker_driver;
  localparam int TICK_DIV   = 8;
  localparam int REPEAT_MAX = 3;
  localparam logic [6:0] FEED   = 7'b0000001;
  localparam logic [6:0] PET    = 7'b0000010;
  localparam logic [6:0] PLAY   = 7'b0000100;
  localparam logic [6:0] SOOTHE = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] energy = 2'b10, stress = 2'b00, pleasure = 2'b10;
  logic       asleep = 1'b0;
  logic       tick;
  logic [6:0] stimuli;
  logic [7:0] action_count;
`ifdef MIMOSA_MANUAL_OVERRIDE_EN
  logic       manual_valid = 1'b0;
  logic [6:0] manual_stim = '0;
  logic       manual_ack;
  int         ack_cnt = 0;
`endif

  int tests = 0, fails = 0;
  int cyc = 0;
  int last_tick_cyc = -1;

  // Reference model state
  logic [6:0] m_last = '0;
  int         m_cnt = 0;
  int         m_count = 0;
  logic [6:0] m_manual = '0;
  bit         m_manual_full = 1'b0;

  caretaker_driver #(.TICK_DIV(TICK_DIV), .REPEAT_MAX(REPEAT_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .energy_indicator(energy),
    .stress_indicator(stress),
    .pleasure_indicator(pleasure),
    .asleep(asleep),
`ifdef MIMOSA_MANUAL_OVERRIDE_EN
    .manual_valid(manual_valid),
    .manual_stim(manual_stim),
    .manual_ack(manual_ack),
`endif
    .tick(tick),
    .stimuli(stimuli),
    .action_count(action_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef MIMOSA_MANUAL_OVERRIDE_EN
  always @(negedge clk) if (manual_ack === 1'b1) ack_cnt <= ack_cnt + 1;
`endif

  function automatic logic [6:0] care_choice(logic [1:0] e, logic [1:0] s, logic [1:0] p, logic a);
    if (a) return 7'd0;
    if (s == 2'b11) return SOOTHE;
    if (e == 2'b00) return FEED;
    if (p <= 2'b01) return (e >= 2'b10) ? PLAY : PET;
    if (p == 2'b10) return PET;
    return 7'd0;
  endfunction

  task automatic model_frame(output logic [6:0] exp);
    logic [6:0] c;
    if (m_manual_full) begin
      exp = m_manual;
      m_manual_full = 1'b0;
    end else begin
      c = care_choice(energy, stress, pleasure, asleep);
      if (c == 7'd0) begin
        exp = 7'd0; m_last = 7'd0; m_cnt = 0;
      end else if (c == m_last && m_cnt == REPEAT_MAX) begin
        exp = 7'd0; m_last = 7'd0; m_cnt = 0;
      end else if (c == m_last) begin
        exp = c; m_cnt++;
      end else begin
        exp = c; m_last = c; m_cnt = 1;
      end
    end
    if (exp != 7'd0 && m_count < 255) m_count++;
  endtask

  // mode 0: normal frame, 1: drop enable on the tick cycle, 2: assert reset in the hold cycle
  task automatic run_frame(input string name, input int mode);
    logic [6:0] exp, prev;
    bit seen;
    int n;
    model_frame(exp);
    prev = stimuli;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (tick === 1'b1) seen = 1'b1;
      else prev = stimuli;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s tick_timeout: no tick within 40 cycles", name);
      return;
    end
    tests++;
    if (prev !== exp) begin
      fails++; $display("FAIL %s setup_stim: got %b want %b", name, prev, exp);
    end
    tests++;
    if (stimuli !== exp) begin
      fails++; $display("FAIL %s tick_stim: got %b want %b", name, stimuli, exp);
    end
    if (last_tick_cyc >= 0) begin
      tests++;
      if (cyc - last_tick_cyc != TICK_DIV) begin
        fails++; $display("FAIL %s tick_period: got %0d want %0d", name, cyc - last_tick_cyc, TICK_DIV);
      end
    end
    last_tick_cyc = cyc;
    if (mode == 1) enable = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (tick !== 1'b0 || stimuli !== exp) begin
      fails++; $display("FAIL %s hold_cycle: got tick=%b stim=%b want tick=0 stim=%b", name, tick, stimuli, exp);
    end
    if (mode == 2) begin
      rst = 1'b1;
      #1;
      tests++;
      if (tick !== 1'b0 || stimuli !== 7'd0 || action_count !== 8'd0) begin
        fails++;
        $display("FAIL %s async_reset: got tick=%b stim=%b count=%0d want 0/0/0", name, tick, stimuli, action_count);
      end
      m_last = 7'd0; m_cnt = 0; m_count = 0; m_manual_full = 1'b0;
      $display("[TB] frame %s reset during hold", name);
      return;
    end
    @(posedge clk); #1;
    tests++;
    if (stimuli !== 7'd0 || tick !== 1'b0) begin
      fails++; $display("FAIL %s frame_end: got tick=%b stim=%b want 0/0", name, tick, stimuli);
    end
    tests++;
    if (action_count !== 8'(m_count)) begin
      fails++; $display("FAIL %s action_count: got %0d want %0d", name, action_count, m_count);
    end
    $display("[TB] frame %s e=%b s=%b p=%b a=%b stim=%b count=%0d", name, energy, stress, pleasure, asleep, exp, action_count);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (tick !== 1'b0 || stimuli !== 7'd0 || action_count !== 8'd0) begin
      fails++; $display("FAIL reset_state: got tick=%b stim=%b count=%0d want 0/0/0", tick, stimuli, action_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    last_tick_cyc = cyc + 1;  // first tick lands TICK_DIV+1 edges after release
  endtask

  task automatic test_soothe();
    energy = 2'b10; pleasure = 2'b10; stress = 2'b11; asleep = 1'b0;
    run_frame("soothe0", 0);
    tests++;
    if (action_count !== 8'd1) begin
      fails++; $display("FAIL first_frame_count: got %0d want 1", action_count);
    end
    for (int i = 1; i < 5; i++) run_frame("soothe", 0);
  endtask

  task automatic test_asleep();
    int saved;
    asleep = 1'b1; stress = 2'b11;
    saved = m_count;
    for (int i = 0; i < 3; i++) run_frame("asleep", 0);
    tests++;
    if (action_count !== 8'(saved)) begin
      fails++; $display("FAIL asleep_count: got %0d want %0d", action_count, saved);
    end
  endtask

  task automatic test_feed_limiter();
    int saved;
    asleep = 1'b0; stress = 2'b00; energy = 2'b00; pleasure = 2'b10;
    saved = m_count;
    for (int i = 0; i < 8; i++) run_frame("feed", 0);
    tests++;
    if (action_count !== 8'(saved + 6)) begin
      fails++; $display("FAIL feed_limiter_count: got %0d want %0d", action_count, saved + 6);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 420; i++) begin
      energy   = 2'($urandom_range(0, 3));
      stress   = 2'($urandom_range(0, 3));
      pleasure = 2'($urandom_range(0, 3));
      asleep   = ($urandom_range(0, 7) == 0);
      run_frame("random", 0);
    end
  endtask

  task automatic test_enable_drop();
    int ticks;
    asleep = 1'b0; stress = 2'b00; energy = 2'b01; pleasure = 2'b10;
    run_frame("drop", 1);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tick !== 1'b0) ticks++;
    end
    tests++;
    if (ticks != 0) begin
      fails++; $display("FAIL disabled_ticks: got %0d want 0", ticks);
    end
    enable = 1'b1;
    last_tick_cyc = cyc + 1;
    run_frame("reenable", 0);
  endtask

  task automatic test_reset_mid();
    asleep = 1'b0; stress = 2'b00; energy = 2'b10; pleasure = 2'b00;
    run_frame("play", 0);
    run_frame("play_rst", 2);
    @(posedge clk); #1;
    rst = 1'b0;
    last_tick_cyc = cyc + 1;
    for (int i = 0; i < 4; i++) run_frame("play_after_rst", 0);
    tests++;
    if (action_count !== 8'd3) begin
      fails++; $display("FAIL post_reset_limiter: got count %0d want 3", action_count);
    end
  endtask

`ifdef MIMOSA_MANUAL_OVERRIDE_EN
  task automatic pulse_manual(input logic [6:0] pat);
    manual_valid = 1'b1;
    manual_stim  = pat;
    if (!m_manual_full) begin
      m_manual = pat; m_manual_full = 1'b1;
    end
    @(posedge clk); #1;
    manual_valid = 1'b0;
  endtask

  task automatic test_manual();
    int saved_ack;
    asleep = 1'b1; stress = 2'b11; energy = 2'b10; pleasure = 2'b10;
    run_frame("manual_prep", 0);
    asleep = 1'b0;
    saved_ack = ack_cnt;
    pulse_manual(7'b1000000);
    pulse_manual(7'b0100000);  // dropped: buffer already full
    run_frame("manual", 0);
    run_frame("after_manual", 0);
    tests++;
    if (ack_cnt - saved_ack != 1) begin
      fails++; $display("FAIL manual_ack_pulses: got %0d want 1", ack_cnt - saved_ack);
    end
    pulse_manual(7'b1010101);
    run_frame("manual_multi", 0);
    run_frame("after_multi", 0);
  endtask
`endif

  initial begin
    test_reset();
    test_soothe();
    test_asleep();
    test_feed_limiter();
    test_random();
    test_enable_drop();
    test_reset_mid();
`ifdef MIMOSA_MANUAL_OVERRIDE_EN
    test_manual();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
